// File: rtl/os_sys_array.sv
// os_sys_array: output-stationary ROWS x COLS systolic multiply-accumulate array.
// Takes one A column and one B row per accepted beat, skews the lanes
// internally, flushes after the last beat, then holds the accumulator tile
// with a one-cycle done pulse.
module os_sys_array #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ROWS      = 2,
  parameter int unsigned COLS      = 2,
  parameter int unsigned ACC_WIDTH = 40
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              in_last,
  input  logic [1:0]                        mode,
  input  logic [ROWS*WIDTH-1:0]             in_a,
  input  logic [COLS*WIDTH-1:0]             in_b,
  output logic [ROWS*COLS*ACC_WIDTH-1:0]    out_c,
  output logic                              calc_done_flag,
  output logic                              busy
);

  localparam int unsigned PROD_W    = 2 * WIDTH;
  localparam int unsigned FLUSH_CYC = ROWS + COLS - 1;
  localparam int unsigned CNT_W     = $clog2(FLUSH_CYC + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_FLUSH  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_in_ready;
  logic             r_busy;
  logic             r_done;
  logic             w_ready_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic [1:0]       r_mode;

  logic             w_accept;
  logic             w_first;
  logic             w_clear;

  // skew lines: stage 0 is the input register, lane r taps stage r
  logic [WIDTH-1:0] r_a_sk [ROWS][ROWS];
  logic [WIDTH-1:0] r_b_sk [COLS][COLS];

  logic [WIDTH-1:0]     r_pe_a     [ROWS][COLS];
  logic [WIDTH-1:0]     r_pe_b     [ROWS][COLS];
  logic [ACC_WIDTH-1:0] r_acc      [ROWS][COLS];
  logic [WIDTH-1:0]     w_a_op     [ROWS][COLS];
  logic [WIDTH-1:0]     w_b_op     [ROWS][COLS];
  logic [ACC_WIDTH-1:0] w_prod_ext [ROWS][COLS];

  assign w_accept = in_valid & r_in_ready;
  assign w_first  = w_accept & (r_state == S_IDLE);
  assign w_clear  = w_first & ~mode[1];

  assign in_ready       = r_in_ready;
  assign busy           = r_busy;
  assign calc_done_flag = r_done;

  // next-state, flush counter and registered-output decode
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (in_last) begin
            w_state_nxt = S_FLUSH;
            w_cnt_nxt   = CNT_W'(FLUSH_CYC);
          end else begin
            w_state_nxt = S_STREAM;
          end
        end
      end
      S_STREAM: begin
        if (w_accept && in_last) begin
          w_state_nxt = S_FLUSH;
          w_cnt_nxt   = CNT_W'(FLUSH_CYC);
        end
      end
      S_FLUSH: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
    w_ready_nxt = (w_state_nxt == S_IDLE) || (w_state_nxt == S_STREAM);
    w_busy_nxt  = (w_state_nxt != S_IDLE);
    w_done_nxt  = (w_state_nxt == S_DONE);
  end

  // state, counter, latched mode and handshake/status registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_mode     <= '0;
      r_in_ready <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_in_ready <= w_ready_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      if (w_first) begin
        r_mode <= mode;
      end
    end
  end

  // input capture and lane skew; idle cycles inject zero bubbles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int j = 0; j < ROWS; j++) begin
          r_a_sk[r][j] <= '0;
        end
      end
      for (int c = 0; c < COLS; c++) begin
        for (int j = 0; j < COLS; j++) begin
          r_b_sk[c][j] <= '0;
        end
      end
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        r_a_sk[r][0] <= w_accept ? in_a[r*WIDTH +: WIDTH] : '0;
        for (int j = 1; j < ROWS; j++) begin
          r_a_sk[r][j] <= r_a_sk[r][j-1];
        end
      end
      for (int c = 0; c < COLS; c++) begin
        r_b_sk[c][0] <= w_accept ? in_b[c*WIDTH +: WIDTH] : '0;
        for (int j = 1; j < COLS; j++) begin
          r_b_sk[c][j] <= r_b_sk[c][j-1];
        end
      end
    end
  end

  // per-PE operand routing and mode-dependent product extension
  for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
    for (genvar gc = 0; gc < COLS; gc++) begin : g_col
      logic [PROD_W-1:0]    w_xa;
      logic [PROD_W-1:0]    w_xb;
      logic [PROD_W-1:0]    w_prod;
      logic [ACC_WIDTH-1:0] w_prod_s;
      logic [ACC_WIDTH-1:0] w_prod_u;

      if (gc == 0) begin : g_a_edge
        assign w_a_op[gr][gc] = r_a_sk[gr][gr];
      end else begin : g_a_pass
        assign w_a_op[gr][gc] = r_pe_a[gr][gc-1];
      end

      if (gr == 0) begin : g_b_edge
        assign w_b_op[gr][gc] = r_b_sk[gc][gc];
      end else begin : g_b_pass
        assign w_b_op[gr][gc] = r_pe_b[gr-1][gc];
      end

      // low 2*WIDTH bits of the extended product equal the exact signed/unsigned product
      assign w_xa = r_mode[0] ? {{WIDTH{w_a_op[gr][gc][WIDTH-1]}}, w_a_op[gr][gc]}
                              : {{WIDTH{1'b0}}, w_a_op[gr][gc]};
      assign w_xb = r_mode[0] ? {{WIDTH{w_b_op[gr][gc][WIDTH-1]}}, w_b_op[gr][gc]}
                              : {{WIDTH{1'b0}}, w_b_op[gr][gc]};
      assign w_prod   = w_xa * w_xb;
      assign w_prod_s = ACC_WIDTH'($signed(w_prod));
      assign w_prod_u = ACC_WIDTH'(w_prod);
      assign w_prod_ext[gr][gc] = r_mode[0] ? w_prod_s : w_prod_u;

      assign out_c[(gr*COLS+gc)*ACC_WIDTH +: ACC_WIDTH] = r_acc[gr][gc];
    end
  end

  // PE pipeline registers and wrapping accumulators
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          r_pe_a[r][c] <= '0;
          r_pe_b[r][c] <= '0;
          r_acc[r][c]  <= '0;
        end
      end
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          r_pe_a[r][c] <= w_a_op[r][c];
          r_pe_b[r][c] <= w_b_op[r][c];
          if (w_clear) begin
            r_acc[r][c] <= '0;
          end else begin
            r_acc[r][c] <= r_acc[r][c] + w_prod_ext[r][c];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_os_sys_array.sv
// Bench for os_sys_array: directed and random jobs against a matrix-product model.
module tb_os_sys_array;

  localparam int unsigned W = 16;
  localparam int unsigned R = 2;
  localparam int unsigned C = 2;
  localparam longint unsigned MASK40 = 64'h0000_00FF_FFFF_FFFF;
  localparam longint unsigned MASK32 = 64'h0000_0000_FFFF_FFFF;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_last;
  logic [1:0]       mode;
  logic [R*W-1:0]   in_a;
  logic [C*W-1:0]   in_b;
  logic             in_ready, in_ready32;
  logic             done40, done32;
  logic             busy40, busy32;
  logic [R*C*40-1:0] out_c40;
  logic [R*C*32-1:0] out_c32;

  os_sys_array #(.WIDTH(W), .ROWS(R), .COLS(C), .ACC_WIDTH(40)) u_dut40 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .mode(mode), .in_a(in_a), .in_b(in_b),
    .out_c(out_c40), .calc_done_flag(done40), .busy(busy40));

  os_sys_array #(.WIDTH(W), .ROWS(R), .COLS(C), .ACC_WIDTH(32)) u_dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready32),
    .in_last(in_last), .mode(mode), .in_a(in_a), .in_b(in_b),
    .out_c(out_c32), .calc_done_flag(done32), .busy(busy32));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  longint unsigned m40 [R][C];
  longint unsigned m32 [R][C];

  logic [R*W-1:0] q_a [$];
  logic [C*W-1:0] q_b [$];
  int             q_gap [$];

  int              g_lat, g_low, g_pulses, g_timeout;
  logic            g_busy_done;
  logic [R*C*40-1:0] g_tile40, g_after40;
  logic [R*C*32-1:0] g_tile32;

  // reference: C = (keep ? C : 0) + sum_k a[k] (outer) b[k], modulo 2^ACC
  task automatic model_job(input logic [1:0] md);
    logic [W-1:0] av, bv;
    longint p;
    if (!md[1]) begin
      for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) begin
        m40[r][c] = 0; m32[r][c] = 0;
      end
    end
    for (int k = 0; k < q_a.size(); k++) begin
      for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) begin
        av = q_a[k][r*W +: W];
        bv = q_b[k][c*W +: W];
        if (md[0]) p = longint'($signed(av)) * longint'($signed(bv));
        else       p = longint'(av) * longint'(bv);
        m40[r][c] = (m40[r][c] + 64'(p)) & MASK40;
        m32[r][c] = (m32[r][c] + 64'(p)) & MASK32;
      end
    end
  endtask

  task automatic clear_q();
    q_a.delete(); q_b.delete(); q_gap.delete();
  endtask

  task automatic load_basic(input int gap);
    clear_q();
    q_a.push_back({16'd2, 16'd1}); q_b.push_back({16'd2, 16'd1}); q_gap.push_back(0);
    q_a.push_back({16'd4, 16'd2}); q_b.push_back({16'd3, 16'd4}); q_gap.push_back(gap);
  endtask

  // drive the queued beats, then measure done latency, ready-low span and tile
  task automatic run_job(input logic [1:0] md);
    int w, j;
    model_job(md);
    g_timeout = 0; g_lat = -1; g_low = 0; g_pulses = 0; g_busy_done = 1'b0;
    for (int k = 0; k < q_a.size(); k++) begin
      for (int g = 0; g < q_gap[k]; g++) begin
        in_valid = 1'b0;
        in_last  = 1'($urandom_range(0, 1));
        in_a     = (R*W)'($urandom);
        in_b     = (C*W)'($urandom);
        mode     = 2'($urandom_range(0, 3));
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_a     = q_a[k];
      in_b     = q_b[k];
      in_last  = (k == q_a.size() - 1);
      mode     = (k == 0) ? md : 2'($urandom_range(0, 3));
      w = 0;
      while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
      if (w >= 50) g_timeout = 1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    j = 0;
    while (j < 60) begin
      if (done40) begin
        g_pulses++;
        if (g_lat < 0) begin
          g_lat = j; g_tile40 = out_c40; g_tile32 = out_c32; g_busy_done = busy40;
        end
      end
      if (in_ready) break;
      g_low++;
      @(posedge clk); #1;
      j++;
    end
    if (j >= 60) g_timeout = 1;
    g_after40 = out_c40;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; mode = 2'b00; in_a = '0; in_b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", in_ready); end
    checks++; if (in_ready32 !== 1'b1) begin errors++; $display("FAIL reset_ready32 got %b want 1", in_ready32); end
    checks++; if (busy40 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy40); end
    checks++; if (done40 !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done40); end
    checks++; if (out_c40 !== '0) begin errors++; $display("FAIL reset_out_c got %h want 0", out_c40); end
    checks++; if (out_c32 !== '0) begin errors++; $display("FAIL reset_out_c32 got %h want 0", out_c32); end
    #3 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    longint ex [R*C] = '{9, 8, 18, 16};
    load_basic(0);
    run_job(2'b00);
    checks++; if (g_timeout != 0) begin errors++; $display("FAIL basic_timeout got %0d want 0", g_timeout); end
    checks++; if (g_lat != int'(R+C-1)) begin errors++; $display("FAIL basic_latency got %0d want %0d", g_lat, R+C-1); end
    checks++; if (g_low != int'(R+C)) begin errors++; $display("FAIL basic_ready_low got %0d want %0d", g_low, R+C); end
    checks++; if (g_pulses != 1) begin errors++; $display("FAIL basic_done_pulses got %0d want 1", g_pulses); end
    checks++; if (g_busy_done !== 1'b1) begin errors++; $display("FAIL basic_busy_in_done got %b want 1", g_busy_done); end
    checks++; if (g_after40 !== g_tile40) begin errors++; $display("FAIL basic_hold got %h want %h", g_after40, g_tile40); end
    for (int i = 0; i < int'(R*C); i++) begin
      checks++;
      if (g_tile40[i*40 +: 40] !== 40'(ex[i])) begin
        errors++; $display("FAIL basic_C%0d got %h want %h", i, g_tile40[i*40 +: 40], 40'(ex[i]));
      end
      checks++;
      if (g_tile40[i*40 +: 40] !== m40[i/C][i%C][39:0]) begin
        errors++; $display("FAIL basic_model_C%0d got %h want %h", i, g_tile40[i*40 +: 40], m40[i/C][i%C][39:0]);
      end
    end
  endtask

  task automatic test_signed();
    longint ex [R*C] = '{-15, 3, 10, -2};
    clear_q();
    q_a.push_back({16'd2, 16'hFFFD}); q_b.push_back({16'hFFFF, 16'd5}); q_gap.push_back(1);
    run_job(2'b01);
    checks++; if (g_lat != int'(R+C-1)) begin errors++; $display("FAIL signed_latency got %0d want %0d", g_lat, R+C-1); end
    for (int i = 0; i < int'(R*C); i++) begin
      checks++;
      if (g_tile40[i*40 +: 40] !== 40'(ex[i])) begin
        errors++; $display("FAIL signed_C%0d got %h want %h", i, g_tile40[i*40 +: 40], 40'(ex[i]));
      end
      checks++;
      if (g_tile32[i*32 +: 32] !== 32'(ex[i])) begin
        errors++; $display("FAIL signed32_C%0d got %h want %h", i, g_tile32[i*32 +: 32], 32'(ex[i]));
      end
    end
  endtask

  task automatic test_bubbles();
    longint ex [R*C] = '{9, 8, 18, 16};
    load_basic(2);
    run_job(2'b00);
    checks++; if (g_lat != int'(R+C-1)) begin errors++; $display("FAIL bubbles_latency got %0d want %0d", g_lat, R+C-1); end
    for (int i = 0; i < int'(R*C); i++) begin
      checks++;
      if (g_tile40[i*40 +: 40] !== 40'(ex[i])) begin
        errors++; $display("FAIL bubbles_C%0d got %h want %h", i, g_tile40[i*40 +: 40], 40'(ex[i]));
      end
    end
  endtask

  task automatic test_accumulate();
    longint ex2 [R*C] = '{18, 16, 36, 32};
    longint ex3 [R*C] = '{9, 8, 18, 16};
    load_basic(0);
    run_job(2'b00);
    run_job(2'b10);
    for (int i = 0; i < int'(R*C); i++) begin
      checks++;
      if (g_tile40[i*40 +: 40] !== 40'(ex2[i])) begin
        errors++; $display("FAIL accum_keep_C%0d got %h want %h", i, g_tile40[i*40 +: 40], 40'(ex2[i]));
      end
    end
    run_job(2'b00);
    for (int i = 0; i < int'(R*C); i++) begin
      checks++;
      if (g_tile40[i*40 +: 40] !== 40'(ex3[i])) begin
        errors++; $display("FAIL accum_clear_C%0d got %h want %h", i, g_tile40[i*40 +: 40], 40'(ex3[i]));
      end
    end
  endtask

  task automatic test_wrap();
    clear_q();
    for (int k = 0; k < 4; k++) begin
      q_a.push_back({R{16'hFFFF}}); q_b.push_back({C{16'hFFFF}}); q_gap.push_back(0);
    end
    run_job(2'b00);
    for (int i = 0; i < int'(R*C); i++) begin
      checks++;
      if (g_tile32[i*32 +: 32] !== 32'hFFF8_0004) begin
        errors++; $display("FAIL wrap32_C%0d got %h want fff80004", i, g_tile32[i*32 +: 32]);
      end
      checks++;
      if (g_tile40[i*40 +: 40] !== 40'h03_FFF8_0004) begin
        errors++; $display("FAIL wrap40_C%0d got %h want 03fff80004", i, g_tile40[i*40 +: 40]);
      end
    end
  endtask

  task automatic test_random();
    int k;
    logic [1:0] md;
    for (int job = 0; job < 8; job++) begin
      clear_q();
      k = $urandom_range(1, 6);
      for (int b = 0; b < k; b++) begin
        q_a.push_back((R*W)'($urandom));
        q_b.push_back((C*W)'($urandom));
        q_gap.push_back(($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
      end
      md = 2'($urandom_range(0, 3));
      run_job(md);
      checks++;
      if (g_lat != int'(R+C-1)) begin errors++; $display("FAIL rand%0d_latency got %0d want %0d", job, g_lat, R+C-1); end
      for (int i = 0; i < int'(R*C); i++) begin
        checks++;
        if (g_tile40[i*40 +: 40] !== m40[i/C][i%C][39:0]) begin
          errors++; $display("FAIL rand%0d_C%0d got %h want %h", job, i, g_tile40[i*40 +: 40], m40[i/C][i%C][39:0]);
        end
        checks++;
        if (g_tile32[i*32 +: 32] !== m32[i/C][i%C][31:0]) begin
          errors++; $display("FAIL rand%0d_c32_%0d got %h want %h", job, i, g_tile32[i*32 +: 32], m32[i/C][i%C][31:0]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_job();
    int pulses;
    int w;
    longint ex [R*C] = '{9, 8, 18, 16};
    load_basic(0);
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_a = q_a[k]; in_b = q_b[k]; in_last = (k == 1); mode = 2'b10;
      w = 0;
      while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy40 !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got %b want 1", busy40); end
    reset = 1'b0;
    #1;
    checks++; if (out_c40 !== '0) begin errors++; $display("FAIL rstmid_out_c got %h want 0", out_c40); end
    checks++; if (out_c32 !== '0) begin errors++; $display("FAIL rstmid_out_c32 got %h want 0", out_c32); end
    checks++; if (busy40 !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy40); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b want 1", in_ready); end
    #4 reset = 1'b1;
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) begin
      m40[r][c] = 0; m32[r][c] = 0;
    end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done40 || done32) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL rstmid_no_done got %0d want 0", pulses); end
    run_job(2'b00);
    for (int i = 0; i < int'(R*C); i++) begin
      checks++;
      if (g_tile40[i*40 +: 40] !== 40'(ex[i])) begin
        errors++; $display("FAIL rstmid_after_C%0d got %h want %h", i, g_tile40[i*40 +: 40], 40'(ex[i]));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_bubbles();
    test_accumulate();
    test_wrap();
    test_random();
    test_reset_mid_job();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
